// File: rtl/sm83_bus_seq.sv
// SM83 bus sequencer: turns one-cycle bus requests into T_PER_M-state memory cycles
// with programmable and memory-stretched wait states and no-bubble back-to-back issue.
module sm83_bus_seq #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int T_PER_M = 4,
  parameter int WAIT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  output logic              m_tick
);

  localparam int TCNT_W = $clog2(T_PER_M);
  localparam logic [TCNT_W-1:0] T_DATA = TCNT_W'(T_PER_M - 2);
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(T_PER_M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TS   = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [TCNT_W-1:0]   tcnt_r, tcnt_nxt_s;
  logic [WAIT_W-1:0]   wcnt_r, wcnt_nxt_s;
  logic [WAIT_W-1:0]   waits_r;
  logic                we_r;
  logic                we_nxt_s;
  logic                accept_s;
  logic                load_s;
  logic                final_s;
  logic                mem_wen_s;
  logic                ready_nxt_s;
  logic                ren_nxt_s;
  logic                tick_nxt_s;
  logic                req_ready_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                mem_ren_r;
  logic                m_tick_r;

  assign accept_s = req_valid & req_ready_r;

  // Next-state logic: T-state counting, data-phase wait/stall stretch and the write strobe.
  always_comb begin
    state_nxt_s = state_r;
    tcnt_nxt_s  = tcnt_r;
    wcnt_nxt_s  = wcnt_r;
    load_s      = 1'b0;
    final_s     = 1'b0;
    mem_wen_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          load_s      = 1'b1;
          state_nxt_s = TS;
          tcnt_nxt_s  = {TCNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TS: begin
        if (tcnt_r == T_LAST) begin
          final_s = 1'b1;
          if (accept_s) begin
            load_s      = 1'b1;
            state_nxt_s = TS;
            tcnt_nxt_s  = {TCNT_W{1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (tcnt_r == T_DATA) begin
          // Data phase: leave for WAIT with tcnt frozen when anything holds it open.
          if ((waits_r != {WAIT_W{1'b0}}) || mem_stall) begin
            state_nxt_s = WAIT;
            wcnt_nxt_s  = (waits_r != {WAIT_W{1'b0}}) ? WAIT_W'(1) : {WAIT_W{1'b0}};
          end else begin
            mem_wen_s  = we_r;
            tcnt_nxt_s = T_LAST;
          end
        end else begin
          tcnt_nxt_s = tcnt_r + TCNT_W'(1);
        end
      end
      WAIT: begin
        if ((wcnt_r == waits_r) && !mem_stall) begin
          mem_wen_s   = we_r;
          state_nxt_s = TS;
          tcnt_nxt_s  = T_LAST;
        end else if (wcnt_r != waits_r) begin
          wcnt_nxt_s = wcnt_r + WAIT_W'(1);
        end else begin
          wcnt_nxt_s = wcnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        tcnt_nxt_s  = {TCNT_W{1'b0}};
        wcnt_nxt_s  = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Decode of the upcoming state so the strobe-style outputs can be registered.
  always_comb begin
    we_nxt_s    = load_s ? req_we : we_r;
    ready_nxt_s = (state_nxt_s == IDLE) || ((state_nxt_s == TS) && (tcnt_nxt_s == T_LAST));
    tick_nxt_s  = (state_nxt_s == TS) && (tcnt_nxt_s == T_LAST);
    ren_nxt_s   = (state_nxt_s != IDLE) && !we_nxt_s;
  end

  // Sequencer state, latched request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      tcnt_r      <= {TCNT_W{1'b0}};
      wcnt_r      <= {WAIT_W{1'b0}};
      waits_r     <= {WAIT_W{1'b0}};
      we_r        <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_ren_r   <= 1'b0;
      m_tick_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tcnt_r      <= tcnt_nxt_s;
      wcnt_r      <= wcnt_nxt_s;
      we_r        <= we_nxt_s;
      req_ready_r <= ready_nxt_s;
      mem_ren_r   <= ren_nxt_s;
      m_tick_r    <= tick_nxt_s;
      rsp_valid_r <= final_s;
      if (load_s) begin
        waits_r     <= wait_cfg;
        mem_addr_r  <= req_addr;
        mem_wdata_r <= req_wdata;
      end
      if (final_s && !we_r) begin
        rsp_rdata_r <= mem_rdata;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_ren   = mem_ren_r;
  assign mem_wen   = mem_wen_s;
  assign m_tick    = m_tick_r;

endmodule
